// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - select-mode encodings and reset values for the stream mux
package stream_mux_pkg;

    localparam logic [1:0] MODE_RR    = 2'd0;
    localparam logic [1:0] MODE_PRIO  = 2'd1;
    localparam logic [1:0] MODE_FORCE = 2'd2;
    localparam logic [1:0] MODE_HOLD  = 2'd3;

    localparam logic RST_OUT_VALID = 1'b0;
    localparam logic RST_OUT_LAST  = 1'b0;
    localparam logic RST_LOCK      = 1'b0;
    localparam int   RST_OUT_DATA  = 0;
    localparam int   RST_OUT_SRC   = 0;
    localparam int   RST_RR_PTR    = 0;
    localparam int   RST_LOCK_CH   = 0;

endpackage

// File: rtl/stream_mux_arb_rr_pick.sv
// rtl/stream_mux_arb_rr_pick.sv - first requester at or after a start index, wrapping mod N_IN
module rr_pick #(
    parameter  int N_IN = 4,
    localparam int SELW = $clog2(N_IN)
) (
    input  logic [N_IN-1:0] req,
    input  logic [SELW-1:0] start,
    output logic            grant_valid,
    output logic [SELW-1:0] grant
);

    logic [N_IN-1:0] rot;
    int              off;
    int              idx;

    always_comb begin
        rot = '0;
        for (int i = 0; i < N_IN; i++) begin
            idx = int'(start) + i;
            if (idx >= N_IN) idx = idx - N_IN;
            rot[i] = req[idx];
        end
    end

    // Descending scan so the lowest rotated offset is the one that sticks.
    always_comb begin
        grant_valid = 1'b0;
        off         = 0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (rot[i]) begin
                grant_valid = 1'b1;
                off         = i;
            end
        end
    end

    always_comb begin
        int g;
        g = int'(start) + off;
        if (g >= N_IN) g = g - N_IN;
        grant = SELW'(g);
    end

endmodule

// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N-input registered stream mux with packet-atomic RR/priority/forced arbitration
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N_IN  = 4,
    localparam int SELW  = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN-1:0]       in_last,
    output logic [N_IN-1:0]       in_ready,
    input  logic [1:0]            mode,
    input  logic [SELW-1:0]       force_sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [SELW-1:0]       out_src,
    input  logic                  out_ready
);

    logic            lock;
    logic [SELW-1:0] lock_ch;
    logic [SELW-1:0] rr_ptr;

    logic            load;
    logic [SELW-1:0] pick_start;
    logic            pick_valid;
    logic [SELW-1:0] pick_grant;
    logic            grant_valid;
    logic [SELW-1:0] grant;
    logic            grant_last;

    assign load = !out_valid | out_ready;

    // Priority mode is round-robin anchored at channel 0.
    assign pick_start = (mode == MODE_RR) ? rr_ptr : '0;

    rr_pick #(.N_IN(N_IN)) u_pick (
        .req         (in_valid),
        .start       (pick_start),
        .grant_valid (pick_valid),
        .grant       (pick_grant)
    );

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (lock) begin
            grant       = lock_ch;
            grant_valid = in_valid[lock_ch];
        end else begin
            case (mode)
                MODE_RR, MODE_PRIO: begin
                    grant       = pick_grant;
                    grant_valid = pick_valid;
                end
                MODE_FORCE: begin
                    if (int'(force_sel) < N_IN) begin
                        grant       = force_sel;
                        grant_valid = in_valid[force_sel];
                    end
                end
                default: begin
                    grant_valid = 1'b0;
                end
            endcase
        end
    end

    assign grant_last = in_last[grant];

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N_IN; k++) begin
            in_ready[k] = !rst & load & grant_valid & (grant == SELW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= RST_OUT_VALID;
            out_data  <= WIDTH'(RST_OUT_DATA);
            out_last  <= RST_OUT_LAST;
            out_src   <= SELW'(RST_OUT_SRC);
            rr_ptr    <= SELW'(RST_RR_PTR);
            lock      <= RST_LOCK;
            lock_ch   <= SELW'(RST_LOCK_CH);
        end else if (load) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant*WIDTH +: WIDTH];
                out_last  <= grant_last;
                out_src   <= grant;
                lock      <= !grant_last;
                if (!grant_last) begin
                    lock_ch <= grant;
                end
                if (grant_last && mode == MODE_RR) begin
                    rr_ptr <= (int'(grant) == N_IN - 1) ? '0 : grant + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb/tb_stream_mux_arb.sv - table-driven self-checking bench for stream_mux_arb
module tb_stream_mux_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_last;
    logic [3:0]   in_ready;
    logic [1:0]   mode;
    logic [1:0]   force_sel;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_last;
    logic [1:0]   out_src;
    logic         out_ready;

    logic         b_rst;
    logic [23:0]  b_in_data;
    logic [2:0]   b_in_valid;
    logic [2:0]   b_in_last;
    logic [2:0]   b_in_ready;
    logic [1:0]   b_mode;
    logic [1:0]   b_force_sel;
    logic [7:0]   b_out_data;
    logic         b_out_valid;
    logic         b_out_last;
    logic [1:0]   b_out_src;
    logic         b_out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_mux_arb #(.WIDTH(32), .N_IN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mode      (mode),
        .force_sel (force_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    stream_mux_arb #(.WIDTH(8), .N_IN(3)) dut_b (
        .clk       (clk),
        .rst       (b_rst),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_last   (b_in_last),
        .in_ready  (b_in_ready),
        .mode      (b_mode),
        .force_sel (b_force_sel),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_last  (b_out_last),
        .out_src   (b_out_src),
        .out_ready (b_out_ready)
    );

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] l;
        logic [1:0] m;
        logic [1:0] fs;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] src;
        logic       ol;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic [1:0] m,
                                logic [1:0] fs, logic ordy, logic [3:0] rdy, logic ov,
                                logic [1:0] src, logic ol);
        vec_t t;
        t.rst = r; t.v = v; t.l = l; t.m = m; t.fs = fs; t.ordy = ordy;
        t.rdy = rdy; t.ov = ov; t.src = src; t.ol = ol;
        return t;
    endfunction

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_data     = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        in_valid    = '0;
        in_last     = '0;
        mode        = 2'd0;
        force_sel   = '0;
        out_ready   = 1'b1;
        b_rst       = 1'b1;
        b_in_data   = {8'hA2, 8'hA1, 8'hA0};
        b_in_valid  = '0;
        b_in_last   = '0;
        b_mode      = 2'd0;
        b_force_sel = '0;
        b_out_ready = 1'b1;

        //            rst  valid    last     mode fs   ordy  in_ready ov  src  ol
        vq.push_back(mk(1, 4'b1111, 4'b1111, 0, 0, 1,   4'b0000, 0, 0, 0)); // 0 reset
        vq.push_back(mk(1, 4'b1111, 4'b1111, 0, 0, 1,   4'b0000, 0, 0, 0));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 1,   4'b0001, 1, 0, 1)); // 2 round-robin
        vq.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 1,   4'b0010, 1, 1, 1));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 1,   4'b0100, 1, 2, 1));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 1,   4'b1000, 1, 3, 1));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 1,   4'b0001, 1, 0, 1)); // wrap
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 0, 4'b0000, 1, 0, 1)); // 7..11 stall
        vq.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 1,   4'b0010, 1, 1, 1)); // 12 release
        vq.push_back(mk(0, 4'b0100, 4'b1111, 0, 0, 1,   4'b0100, 1, 2, 1));
        vq.push_back(mk(0, 4'b1000, 4'b1111, 0, 0, 1,   4'b1000, 1, 3, 1));
        vq.push_back(mk(0, 4'b0001, 4'b1111, 0, 0, 1,   4'b0001, 1, 0, 1)); // rr_ptr -> 1
        vq.push_back(mk(0, 4'b0111, 4'b0000, 0, 0, 1,   4'b0010, 1, 1, 0)); // 16 ch1 packet
        vq.push_back(mk(0, 4'b0111, 4'b0000, 0, 0, 1,   4'b0010, 1, 1, 0));
        vq.push_back(mk(0, 4'b0101, 4'b0000, 0, 0, 1,   4'b0000, 0, 1, 0)); // gap
        vq.push_back(mk(0, 4'b0101, 4'b0000, 0, 0, 1,   4'b0000, 0, 1, 0));
        vq.push_back(mk(0, 4'b0111, 4'b0010, 0, 0, 1,   4'b0010, 1, 1, 1)); // last beat
        vq.push_back(mk(0, 4'b0101, 4'b0101, 0, 0, 1,   4'b0100, 1, 2, 1));
        vq.push_back(mk(0, 4'b0011, 4'b1111, 2, 2, 1,   4'b0000, 0, 2, 1)); // 22 forced, ch2 idle
        vq.push_back(mk(0, 4'b0111, 4'b1111, 2, 2, 1,   4'b0100, 1, 2, 1));
        vq.push_back(mk(0, 4'b1001, 4'b0000, 0, 0, 1,   4'b1000, 1, 3, 0)); // 24 ch3 packet
        vq.push_back(mk(0, 4'b1001, 4'b1000, 1, 0, 1,   4'b1000, 1, 3, 1)); // mode flips mid-packet
        vq.push_back(mk(0, 4'b1110, 4'b1111, 1, 0, 1,   4'b0010, 1, 1, 1));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 1,   4'b1000, 1, 3, 1)); // rr_ptr still 3
        vq.push_back(mk(0, 4'b1111, 4'b1111, 3, 0, 1,   4'b0000, 0, 3, 1)); // hold mode
        vq.push_back(mk(0, 4'b1111, 4'b0000, 0, 0, 1,   4'b0001, 1, 0, 0)); // 29 lock ch0
        vq.push_back(mk(1, 4'b1111, 4'b0000, 0, 0, 1,   4'b0000, 0, 0, 0)); // reset mid-packet
        vq.push_back(mk(0, 4'b0010, 4'b0010, 0, 0, 1,   4'b0010, 1, 1, 1)); // lock discarded

        foreach (vq[i]) begin
            @(negedge clk);
            rst       = vq[i].rst;
            in_valid  = vq[i].v;
            in_last   = vq[i].l;
            mode      = vq[i].m;
            force_sel = vq[i].fs;
            out_ready = vq[i].ordy;
            #1;
            check("in_ready", i, 32'(in_ready), 32'(vq[i].rdy));
            @(posedge clk);
            #1;
            check("out_valid", i, 32'(out_valid), 32'(vq[i].ov));
            check("out_src", i, 32'(out_src), 32'(vq[i].src));
            check("out_last", i, 32'(out_last), 32'(vq[i].ol));
            check("out_data", i, out_data, 32'(vq[i].src) * 32'h11111111);
        end

        // Out-of-range force_sel on a 3-channel mux: index 3 must simply not grant.
        @(negedge clk);
        b_rst = 1'b1;
        b_in_valid = 3'b111;
        @(posedge clk);
        #1;
        check("b_reset_valid", 100, 32'(b_out_valid), 32'd0);
        @(negedge clk);
        b_rst = 1'b0;
        b_mode = 2'd2;
        b_force_sel = 2'd3;
        b_in_last = 3'b111;
        #1;
        check("b_oor_ready", 101, 32'(b_in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("b_oor_valid", 102, 32'(b_out_valid), 32'd0);
        @(negedge clk);
        b_force_sel = 2'd2;
        #1;
        check("b_force_ready", 103, 32'(b_in_ready), 32'b100);
        @(posedge clk);
        #1;
        check("b_force_valid", 104, 32'(b_out_valid), 32'd1);
        check("b_force_src", 105, 32'(b_out_src), 32'd2);
        check("b_force_data", 106, 32'(b_out_data), 32'hA2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
